rvcpu_bus_arbiter: RTL and testbench

- Parametrised N-channel memory-bus arbiter and address decoder; successor to the single-port IF/MEM shared-bus mux at the CPU top.
- Accepts valid/ready requests from NUM_CH requestors (channel 0 = instruction fetch, channel 1 = load/store, further channels spare).
- Grants one requestor per transaction, either fixed-priority or round-robin.
- Routes the granted request to the RAM port or the MMIO (CLINT) port by address window, with a timeout that returns an error response.

---
 rtl/rvcpu_bus_arbiter_pkg.sv | 30 +++
 rtl/rvcpu_bus_arbiter_rr_arbiter.sv | 37 +++
 rtl/rvcpu_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 tb/tb_rvcpu_bus_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvcpu_bus_arbiter_pkg.sv
// Shared definitions for the CPU memory-bus arbiter: state encoding,
// response codes, access size codes and the default RAM window base.
package rvcpu_bus_arbiter_pkg;

    localparam logic [1:0] ST_IDLE_ENC = 2'b00;
    localparam logic [1:0] ST_RAM_ENC  = 2'b01;
    localparam logic [1:0] ST_MMIO_ENC = 2'b10;
    localparam logic [1:0] ST_RESP_ENC = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE      = ST_IDLE_ENC,
        S_RAM_BUSY  = ST_RAM_ENC,
        S_MMIO_BUSY = ST_MMIO_ENC,
        S_RESP      = ST_RESP_ENC
    } state_t;

    localparam logic [1:0] RESP_OK      = 2'b00;
    localparam logic [1:0] RESP_TIMEOUT = 2'b10;

    // Doubleword access size code.
    localparam logic [1:0] SIZE_D = 2'b11;

    localparam logic [63:0] DEFAULT_RAM_BASE = 64'h8000_0000;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rvcpu_bus_arbiter_rr_arbiter.sv
// Combinational request picker. In round-robin mode the search starts at
// ptr and wraps; in fixed mode it starts at channel 0. Produces a one-hot
// grant and the encoded index of the winner.
module rvcpu_bus_arbiter_rr_arbiter
    import rvcpu_bus_arbiter_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    input  logic              rr_mode,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  idx
);

    // Scan channels in priority order and take the first requesting one.
    always_comb begin
        int  cand;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = rr_mode ? ((int'(ptr) + k) % NUM_CH) : k;
            for (int j = 0; j < NUM_CH; j++) begin
                if (!found && (j == cand) && req[j]) begin
                    found    = 1'b1;
                    grant[j] = 1'b1;
                    idx      = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/rvcpu_bus_arbiter.sv
// N-channel memory-bus arbiter with RAM/MMIO address decode and a
// downstream wait timeout. One transaction in flight at a time.
//
//   state       | meaning
//   ------------+--------------------------------------------------------
//   S_IDLE      | waiting for any ch_valid; winner fields latched on grant
//   S_RAM_BUSY  | ram_valid held until ram_ready or timeout
//   S_MMIO_BUSY | mmio_valid held until mmio_ready or timeout
//   S_RESP      | one-cycle ch_ready pulse to the winner, advance rr_ptr
module rvcpu_bus_arbiter
    import rvcpu_bus_arbiter_pkg::*;
#(
    parameter int          NUM_CH   = 2,
    parameter int          ADDR_W   = 64,
    parameter int          DATA_W   = 64,
    parameter logic [63:0] RAM_BASE = DEFAULT_RAM_BASE,
    parameter int          RR_MODE  = 1,
    parameter int          TIMEOUT  = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          ch_valid,
    input  logic [NUM_CH-1:0]          ch_write,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
    input  logic [NUM_CH*DATA_W/8-1:0] ch_wmask,
    input  logic [NUM_CH*2-1:0]        ch_size,
    output logic [NUM_CH-1:0]          ch_ready,
    output logic [DATA_W-1:0]          ch_rdata,
    output logic [1:0]                 ch_resp,
    output logic                       ram_valid,
    output logic                       ram_write,
    output logic [ADDR_W-1:0]          ram_addr,
    output logic [DATA_W-1:0]          ram_wdata,
    output logic [DATA_W/8-1:0]        ram_wmask,
    output logic [1:0]                 ram_size,
    input  logic                       ram_ready,
    input  logic [DATA_W-1:0]          ram_rdata,
    input  logic [1:0]                 ram_resp,
    output logic                       mmio_valid,
    output logic                       mmio_write,
    output logic [ADDR_W-1:0]          mmio_addr,
    output logic [DATA_W-1:0]          mmio_wdata,
    output logic [DATA_W/8-1:0]        mmio_wmask,
    input  logic                       mmio_ready,
    input  logic [DATA_W-1:0]          mmio_rdata
);

    localparam int MASK_W = DATA_W / 8;
    localparam int IDX_W  = idx_width(NUM_CH);
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [ADDR_W-1:0] RAM_BASE_A = ADDR_W'(RAM_BASE);
    // The counter is checked before it increments, so the last waiting
    // cycle is the one where it still reads TIMEOUT-1.
    localparam logic [CNT_W-1:0]  TO_LAST    = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [IDX_W-1:0]  LAST_CH    = IDX_W'(NUM_CH - 1);
    localparam logic              RR_EN      = (RR_MODE != 0);

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    rr_ptr;
    logic [NUM_CH-1:0]   grant;
    logic [IDX_W-1:0]    win_idx;

    logic [IDX_W-1:0]    win_q;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;
    logic [1:0]          size_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          resp_q;
    logic [CNT_W-1:0]    to_cnt;

    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [MASK_W-1:0]   sel_wmask;
    logic [1:0]          sel_size;

    logic                busy;
    logic                dn_ready;
    logic                to_hit;
    logic                cap;
    logic [DATA_W-1:0]   cap_rdata;
    logic [1:0]          cap_resp;

    rvcpu_bus_arbiter_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req     (ch_valid),
        .ptr     (rr_ptr),
        .rr_mode (RR_EN),
        .grant   (grant),
        .idx     (win_idx)
    );

    assign busy     = (state == S_RAM_BUSY) || (state == S_MMIO_BUSY);
    assign dn_ready = (state == S_RAM_BUSY) ? ram_ready : mmio_ready;
    assign to_hit   = (TIMEOUT != 0) && (to_cnt == TO_LAST);

    // One-hot AND-OR mux of the granted channel's request fields.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wmask = '0;
        sel_size  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                sel_write = ch_write[i];
                sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = ch_wdata[i*DATA_W +: DATA_W];
                sel_wmask = ch_wmask[i*MASK_W +: MASK_W];
                sel_size  = ch_size[i*2 +: 2];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, downstream port drive and response capture.
    always_comb begin
        state_nxt  = state;
        cap        = 1'b0;
        cap_rdata  = '0;
        cap_resp   = RESP_OK;
        ram_valid  = 1'b0;
        ram_write  = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        ram_wmask  = '0;
        ram_size   = '0;
        mmio_valid = 1'b0;
        mmio_write = 1'b0;
        mmio_addr  = '0;
        mmio_wdata = '0;
        mmio_wmask = '0;
        case (state)
            S_IDLE: begin
                if (|grant) begin
                    state_nxt = (sel_addr >= RAM_BASE_A) ? S_RAM_BUSY : S_MMIO_BUSY;
                end
            end
            S_RAM_BUSY: begin
                ram_valid = 1'b1;
                ram_write = write_q;
                ram_addr  = {addr_q[ADDR_W-1:3], 3'b000};
                ram_wdata = write_q ? wdata_q : '0;
                ram_wmask = write_q ? wmask_q : '0;
                ram_size  = size_q;
                if (ram_ready) begin
                    cap       = 1'b1;
                    cap_rdata = write_q ? '0 : ram_rdata;
                    cap_resp  = ram_resp;
                    state_nxt = S_RESP;
                end else if (to_hit) begin
                    cap       = 1'b1;
                    cap_resp  = RESP_TIMEOUT;
                    state_nxt = S_RESP;
                end
            end
            S_MMIO_BUSY: begin
                mmio_valid = 1'b1;
                mmio_write = write_q;
                mmio_addr  = addr_q;
                mmio_wdata = write_q ? wdata_q : '0;
                mmio_wmask = write_q ? wmask_q : '0;
                if (mmio_ready) begin
                    cap       = 1'b1;
                    cap_rdata = write_q ? '0 : mmio_rdata;
                    cap_resp  = RESP_OK;
                    state_nxt = S_RESP;
                end else if (to_hit) begin
                    cap       = 1'b1;
                    cap_resp  = RESP_TIMEOUT;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Grant latch, timeout counter, captured response and rr pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr  <= '0;
            win_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            size_q  <= '0;
            rdata_q <= '0;
            resp_q  <= '0;
            to_cnt  <= '0;
        end else begin
            if ((state == S_IDLE) && (|grant)) begin
                win_q   <= win_idx;
                write_q <= sel_write;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                wmask_q <= sel_wmask;
                size_q  <= sel_size;
            end
            if (busy && !dn_ready) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (cap) begin
                rdata_q <= cap_rdata;
                resp_q  <= cap_resp;
            end
            if (state == S_RESP) begin
                to_cnt <= '0;
                if (RR_EN) begin
                    rr_ptr <= (win_q == LAST_CH) ? '0 : (win_q + 1'b1);
                end
            end
        end
    end

    // Requestor response; everything reads zero outside the RESP cycle.
    always_comb begin
        ch_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_ready[i] = (state == S_RESP) && (win_q == IDX_W'(i));
        end
        ch_rdata = (state == S_RESP) ? rdata_q : '0;
        ch_resp  = (state == S_RESP) ? resp_q : '0;
    end

endmodule

// File: tb/tb_rvcpu_bus_arbiter.sv
// Scoreboard bench for rvcpu_bus_arbiter. A round-robin instance is the
// main DUT; a fixed-priority twin shares its request inputs so grant order
// can be compared between the two modes.
module tb_rvcpu_bus_arbiter;
    import rvcpu_bus_arbiter_pkg::*;

    typedef struct {
        logic [1:0]  rdy;
        logic [63:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   ch_valid = '0;
    logic [1:0]   ch_write = '0;
    logic [127:0] ch_addr  = '0;
    logic [127:0] ch_wdata = '0;
    logic [15:0]  ch_wmask = '0;
    logic [3:0]   ch_size  = '0;
    logic         ram_ready = 1'b0, fp_ram_ready = 1'b0;
    logic         mmio_ready = 1'b0, fp_mmio_ready = 1'b0;
    logic [63:0]  ram_rdata = '0;
    logic [1:0]   ram_resp = '0;
    logic [63:0]  mmio_rdata = '0;

    logic [1:0]   ch_ready, fp_ch_ready;
    logic [63:0]  ch_rdata, fp_ch_rdata;
    logic [1:0]   ch_resp, fp_ch_resp;
    logic         ram_valid, ram_write, fp_ram_valid, fp_ram_write;
    logic [63:0]  ram_addr, ram_wdata, fp_ram_addr, fp_ram_wdata;
    logic [7:0]   ram_wmask, fp_ram_wmask;
    logic [1:0]   ram_size, fp_ram_size;
    logic         mmio_valid, mmio_write, fp_mmio_valid, fp_mmio_write;
    logic [63:0]  mmio_addr, mmio_wdata, fp_mmio_addr, fp_mmio_wdata;
    logic [7:0]   mmio_wmask, fp_mmio_wmask;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_ready = 0;
    int   fp_n = 0;
    logic fp_chk = 1'b0;
    logic ram_en = 1'b0;
    logic mmio_en = 1'b0;
    logic ram_fixed = 1'b1;
    logic [63:0] ram_data_v = '0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    rvcpu_bus_arbiter #(
        .NUM_CH(2), .ADDR_W(64), .DATA_W(64), .RAM_BASE(64'h8000_0000),
        .RR_MODE(1), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_valid(ch_valid), .ch_write(ch_write), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_wmask(ch_wmask), .ch_size(ch_size),
        .ch_ready(ch_ready), .ch_rdata(ch_rdata), .ch_resp(ch_resp),
        .ram_valid(ram_valid), .ram_write(ram_write), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_size(ram_size),
        .ram_ready(ram_ready), .ram_rdata(ram_rdata), .ram_resp(ram_resp),
        .mmio_valid(mmio_valid), .mmio_write(mmio_write), .mmio_addr(mmio_addr),
        .mmio_wdata(mmio_wdata), .mmio_wmask(mmio_wmask),
        .mmio_ready(mmio_ready), .mmio_rdata(mmio_rdata)
    );

    rvcpu_bus_arbiter #(
        .NUM_CH(2), .ADDR_W(64), .DATA_W(64), .RAM_BASE(64'h8000_0000),
        .RR_MODE(0), .TIMEOUT(4)
    ) dut_fp (
        .clk(clk), .rst(rst),
        .ch_valid(ch_valid), .ch_write(ch_write), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_wmask(ch_wmask), .ch_size(ch_size),
        .ch_ready(fp_ch_ready), .ch_rdata(fp_ch_rdata), .ch_resp(fp_ch_resp),
        .ram_valid(fp_ram_valid), .ram_write(fp_ram_write), .ram_addr(fp_ram_addr),
        .ram_wdata(fp_ram_wdata), .ram_wmask(fp_ram_wmask), .ram_size(fp_ram_size),
        .ram_ready(fp_ram_ready), .ram_rdata(ram_rdata), .ram_resp(ram_resp),
        .mmio_valid(fp_mmio_valid), .mmio_write(fp_mmio_write), .mmio_addr(fp_mmio_addr),
        .mmio_wdata(fp_mmio_wdata), .mmio_wmask(fp_mmio_wmask),
        .mmio_ready(fp_mmio_ready), .mmio_rdata(mmio_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Downstream model: ready follows valid when the port is enabled.
    task automatic respond();
        ram_ready     = ram_en && ram_valid;
        fp_ram_ready  = ram_en && fp_ram_valid;
        mmio_ready    = mmio_en && mmio_valid;
        fp_mmio_ready = mmio_en && fp_mmio_valid;
        ram_rdata     = ram_fixed ? ram_data_v : {32'hA5A5_5A5A, ram_addr[31:0]};
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (ch_ready != 2'b00) begin
            n_ready++;
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 64'(ch_ready), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("ready", 64'(ch_ready), 64'(e.rdy));
                check("rdata", ch_rdata, e.rdata);
                check("resp", 64'(ch_resp), 64'(e.resp));
            end
        end else begin
            check("idle_rdata", ch_rdata, 64'd0);
            check("idle_resp", 64'(ch_resp), 64'd0);
        end
        if (fp_chk && (fp_ch_ready != 2'b00)) begin
            fp_n++;
            check("fp_grant", 64'(fp_ch_ready), 64'd1);
        end
        respond();
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check("drain_budget", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic set_ch(input int ch, input logic v, input logic w,
                          input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] m, input logic [1:0] s);
        ch_valid[ch]         = v;
        ch_write[ch]         = w;
        ch_addr[ch*64 +: 64] = a;
        ch_wdata[ch*64 +: 64] = d;
        ch_wmask[ch*8 +: 8]  = m;
        ch_size[ch*2 +: 2]   = s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int vcnt;

        // Reset state
        tick();
        tick();
        check("rst_ch_ready", 64'(ch_ready), 64'd0);
        check("rst_ram_valid", 64'(ram_valid), 64'd0);
        check("rst_mmio_valid", 64'(mmio_valid), 64'd0);
        check("rst_ram_addr", ram_addr, 64'd0);
        rst = 1'b1;
        tick();

        // Single RAM read, ready on the first busy cycle
        ram_en = 1'b1; ram_fixed = 1'b1; ram_data_v = 64'hDEAD_BEEF_0123_4567;
        set_ch(0, 1'b1, 1'b0, 64'h8000_0004, 64'h1111_2222_3333_4444, 8'hFF, SIZE_D);
        exp_q.push_back('{2'b01, 64'hDEAD_BEEF_0123_4567, 2'b00});
        n0 = n_ready;
        tick();
        check("rd_ram_valid", 64'(ram_valid), 64'd1);
        check("rd_ram_addr", ram_addr, 64'h8000_0000);
        check("rd_ram_write", 64'(ram_write), 64'd0);
        check("rd_ram_wdata", ram_wdata, 64'd0);
        check("rd_ram_wmask", 64'(ram_wmask), 64'd0);
        check("rd_ram_size", 64'(ram_size), 64'(SIZE_D));
        check("rd_mmio_valid", 64'(mmio_valid), 64'd0);
        tick();
        // ch_valid presented in cycle 1, ready appears in cycle 3
        check("rd_latency", 64'(n_ready - n0), 64'd1);
        ch_valid = 2'b00;
        tick();

        // Address changed after grant is ignored; downstream resp passes through
        ram_en = 1'b0; ram_fixed = 1'b0; ram_resp = 2'b11;
        set_ch(0, 1'b1, 1'b0, 64'h8000_0100, 64'd0, 8'h00, SIZE_D);
        exp_q.push_back('{2'b01, 64'hA5A5_5A5A_8000_0100, 2'b11});
        tick();
        check("latch_addr_a", ram_addr, 64'h8000_0100);
        ch_addr[63:0] = 64'h9000_0000;
        tick();
        check("latch_addr_b", ram_addr, 64'h8000_0100);
        ram_en = 1'b1;
        respond();
        wait_drain(5);
        ch_valid = 2'b00; ram_resp = 2'b00;
        tick();

        // ch1 write to the MMIO window
        mmio_en = 1'b1; mmio_rdata = 64'h5555_AAAA_5555_AAAA;
        set_ch(1, 1'b1, 1'b1, 64'h0200_4000, 64'h0123_4567_89AB_CDEF, 8'hFF, SIZE_D);
        exp_q.push_back('{2'b10, 64'd0, 2'b00});
        tick();
        check("mm_valid", 64'(mmio_valid), 64'd1);
        check("mm_addr", mmio_addr, 64'h0200_4000);
        check("mm_write", 64'(mmio_write), 64'd1);
        check("mm_wdata", mmio_wdata, 64'h0123_4567_89AB_CDEF);
        check("mm_wmask", 64'(mmio_wmask), 64'hFF);
        check("mm_ram_valid", 64'(ram_valid), 64'd0);
        wait_drain(5);
        ch_valid = 2'b00;
        tick();

        // Both channels requesting continuously: RR alternates, FP stays on ch0
        set_ch(0, 1'b1, 1'b0, 64'h8000_1008, 64'd0, 8'h00, SIZE_D);
        set_ch(1, 1'b1, 1'b0, 64'h8000_2010, 64'd0, 8'h00, SIZE_D);
        for (int t = 0; t < 2; t++) begin
            exp_q.push_back('{2'b01, 64'hA5A5_5A5A_8000_1008, 2'b00});
            exp_q.push_back('{2'b10, 64'hA5A5_5A5A_8000_2010, 2'b00});
        end
        fp_chk = 1'b1; fp_n = 0;
        wait_drain(30);
        ch_valid = 2'b00;
        fp_chk = 1'b0;
        check("fp_count", 64'(fp_n), 64'd4);
        tick();

        // RAM never ready: timeout after four waiting cycles
        ram_en = 1'b0; ram_fixed = 1'b1; ram_data_v = 64'hFFFF_FFFF_FFFF_FFFF;
        respond();
        set_ch(0, 1'b1, 1'b0, 64'h8000_0040, 64'd0, 8'h00, SIZE_D);
        exp_q.push_back('{2'b01, 64'd0, 2'b10});
        vcnt = 0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            tick();
            if (ram_valid) vcnt++;
        end
        check("to_drain", 64'(exp_q.size()), 64'd0);
        check("to_valid_cycles", 64'(vcnt), 64'd4);
        ch_valid = 2'b00;
        tick();

        // Asynchronous reset mid-transaction, then a fresh request
        set_ch(0, 1'b1, 1'b0, 64'h8000_0080, 64'd0, 8'h00, SIZE_D);
        tick();
        check("rst_pre_valid", 64'(ram_valid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_ram_valid", 64'(ram_valid), 64'd0);
        check("arst_ram_addr", ram_addr, 64'd0);
        check("arst_ch_ready", 64'(ch_ready), 64'd0);
        check("arst_mmio_valid", 64'(mmio_valid), 64'd0);
        n0 = n_ready;
        tick();
        tick();
        tick();
        check("arst_no_ready", 64'(n_ready - n0), 64'd0);
        rst = 1'b1;
        ram_en = 1'b1; ram_fixed = 1'b0;
        set_ch(0, 1'b1, 1'b0, 64'h8000_0200, 64'd0, 8'h00, SIZE_D);
        set_ch(1, 1'b1, 1'b0, 64'h8000_0300, 64'd0, 8'h00, SIZE_D);
        respond();
        exp_q.push_back('{2'b01, 64'hA5A5_5A5A_8000_0200, 2'b00});
        exp_q.push_back('{2'b10, 64'hA5A5_5A5A_8000_0300, 2'b00});
        wait_drain(20);
        ch_valid = 2'b00;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
